add_arb: RTL

ADD_ARB -- requirements
Module: add_arb

---
 rtl/add_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/add_arb.sv
// add_arb: two-requester round-robin front end for an external 4-stage
// pipelined adder. Tracks in-flight operations with a {valid, tag} shift
// register that mirrors the adder pipeline, so each result is routed back to
// the requester that issued it. The adder is frozen while the head result
// waits for its owner.
module add_arb #(
  parameter int W   = 32,
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [1:0]   req_cin,
  output logic [1:0]   res_valid,
  input  logic [1:0]   res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  output logic         add_stop,
  output logic         add_rst,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         busy,
  output logic [15:0]  issue_cnt
);

  // Round-robin pointer: requester that wins when both are valid.
  logic           rr_reg;
  // Two-flop release sequence so the adder clear covers the first edge
  // after reset deassertion.
  logic           rst_hold_reg;
  logic           add_rst_reg;
  // Index 0 is the entry slot (adder stage 1), index LAT-1 is the head
  // (lined up with the adder's stage-4 output).
  logic [LAT-1:0] slot_valid_reg;
  logic [LAT-1:0] slot_tag_reg;
  logic [15:0]    issue_cnt_reg;

  logic [1:0]     grant;
  logic           grant_idx;
  logic           issue_ok;
  logic           handshake;
  logic           head_valid;
  logic           head_tag;

  assign head_valid = slot_valid_reg[LAT-1];
  assign head_tag   = slot_tag_reg[LAT-1];

  // Freeze only on a real result whose owner is not ready; bubbles never stall.
  assign add_stop  = head_valid & ~res_ready[head_tag];
  assign add_rst   = add_rst_reg;
  assign issue_ok  = ~add_stop & ~add_rst_reg;

  // Arbitration: a lone requester always wins, otherwise the pointer decides.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = rr_reg ? 2'b10 : 2'b01;
    end
  end

  assign grant_idx = grant[1];
  assign req_ready = issue_ok ? grant : 2'b00;
  assign handshake = |(req_ready & req_valid);

  // Steer the granted requester's operands to the adder; zero when idle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant[0]) begin
      add_a   = req_a0;
      add_b   = req_b0;
      add_cin = req_cin[0];
    end else if (grant[1]) begin
      add_a   = req_a1;
      add_b   = req_b1;
      add_cin = req_cin[1];
    end
  end

  // Result routing: one valid bit per requester, decoded from the head tag.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_res
      assign res_valid[gi] = head_valid & (head_tag == 1'(gi));
    end
  endgenerate

  // Sum and carry are shared; the adder output is already aligned with the head.
  assign res_sum   = add_sum;
  assign res_cout  = add_cout;
  assign busy      = |slot_valid_reg;
  assign issue_cnt = issue_cnt_reg;

  // Hold the adder clear through the first post-reset edge, release at the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_hold_reg <= 1'b1;
      add_rst_reg  <= 1'b1;
    end else begin
      rst_hold_reg <= 1'b0;
      add_rst_reg  <= rst_hold_reg;
    end
  end

  // Tracking shift register advances in lockstep with the adder pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_reg <= '0;
      slot_tag_reg   <= '0;
    end else if (!add_stop) begin
      slot_valid_reg <= {slot_valid_reg[LAT-2:0], handshake};
      slot_tag_reg   <= {slot_tag_reg[LAT-2:0], handshake & grant_idx};
    end
  end

  // After each accepted request, priority passes to the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg        <= 1'b0;
      issue_cnt_reg <= 16'd0;
    end else if (handshake) begin
      rr_reg        <= ~grant_idx;
      issue_cnt_reg <= issue_cnt_reg + 16'd1;
    end
  end

endmodule
